// File: rtl/inst_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
// Shared constants, FSM state type and a byte-lane helper for the instruction
// fetch controller.
//   RST_ENABLE / TRUE_V / FALSE_V : logic levels used across the slice
//   ZERO_WORD                     : 32-bit all-zero instruction word
//   INST_ADDR_W / RAM_ADDR_W      : instruction bus and RAM byte address widths
//   fetch_state_e                 : IDLE / FETCH / DRAIN controller states
//   set_lane()                    : replace one little-endian byte lane of a word
// -----------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

    localparam logic        RST_ENABLE  = 1'b1;
    localparam logic        TRUE_V      = 1'b1;
    localparam logic        FALSE_V     = 1'b0;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam int          INST_ADDR_W = 32;
    localparam int          RAM_ADDR_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10
    } fetch_state_e;

    // Lane 0 is bits [7:0] (byte at the lowest address).
    function automatic logic [31:0] set_lane(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [7:0]  data_b
    );
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = data_b;
            2'd1:    res[15:8]  = data_b;
            2'd2:    res[23:16] = data_b;
            2'd3:    res[31:24] = data_b;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_if
// Byte-wide RAM port seen through the memory arbiter.
//   mem_req : request for the RAM port (controller -> arbiter)
//   mem_gnt : grant; mem_a reaches the RAM only in granted cycles
//   mem_a   : RAM byte address
//   mem_din : read data, byte for mem_a returned one cycle later
// Modports: master = fetch controller, slave = arbiter/RAM side.
// -----------------------------------------------------------------------------
interface inst_fetch_ctrl_if
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) ();

    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_din;

    modport master (
        output mem_req,
        output mem_a,
        input  mem_gnt,
        input  mem_din
    );

    modport slave (
        input  mem_req,
        input  mem_a,
        output mem_gnt,
        output mem_din
    );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Instruction fetch controller between the IF stage and the 8-bit unified RAM.
// Each 32-bit fetch becomes four byte reads (A..A+3) assembled little-endian.
// A one-entry last-word buffer answers a repeat fetch of the same word in one
// cycle without touching RAM.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rdy         : global ready, low freezes every register
//   inst_re     : one-cycle fetch strobe; while busy it redirects the fetch
//   inst_raddr  : fetch byte address (bits [1:0] and above ADDR_W ignored)
//   inst_flush  : invalidate the last-word buffer
//   inst_rdata  : assembled word, valid while inst_busy=0 after a fetch
//   inst_busy   : high while a fetch is outstanding
//   mem         : RAM/arbiter port (master modport)
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter bit USE_BUF = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   inst_re,
    input  logic [INST_ADDR_W-1:0] inst_raddr,
    input  logic                   inst_flush,
    output logic [31:0]            inst_rdata,
    output logic                   inst_busy,
    inst_fetch_ctrl_if.master      mem
);

    fetch_state_e      state_r,     state_s;
    logic [ADDR_W-1:0] addr_r,      addr_s;
    logic [1:0]        idx_r,       idx_s;
    logic              pend_r,      pend_s;
    logic [1:0]        tag_r,       tag_s;
    logic [31:0]       asm_r,       asm_s;
    logic [31:0]       rdata_r,     rdata_s;
    logic              busy_r,      busy_s;
    logic              req_r,       req_s;
    logic [ADDR_W-1:0] mem_a_r,     mem_a_s;
    logic              buf_valid_r, buf_valid_s;
    logic [ADDR_W-1:0] buf_addr_r,  buf_addr_s;
    logic [31:0]       buf_data_r,  buf_data_s;

    logic [ADDR_W-1:0] req_addr_s;
    logic              hit_s;
    logic              complete_s;
    logic              unused_raddr_s;

    // Byte offset and bits above the RAM range do not select anything.
    assign unused_raddr_s = ^inst_raddr;
    assign req_addr_s     = {inst_raddr[ADDR_W-1:2], 2'b00};

    // A hit is only taken from IDLE; a request while busy always restarts RAM reads.
    assign hit_s = (USE_BUF == 1'b1) && buf_valid_r && (buf_addr_r == req_addr_s) &&
                   !inst_flush && (state_r == ST_IDLE);

    // The last byte lands this edge unless a new request discards the fetch.
    assign complete_s = pend_r && (tag_r == 2'd3) && !inst_re;

    assign inst_rdata  = rdata_r;
    assign inst_busy   = busy_r;
    assign mem.mem_req = req_r;
    assign mem.mem_a   = mem_a_r;

    // Next-state and datapath update applied at the next rdy=1 edge.
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        idx_s    = idx_r;
        pend_s   = pend_r;
        tag_s    = tag_r;
        busy_s   = busy_r;
        req_s    = req_r;
        mem_a_s  = mem_a_r;

        // Byte issue: index and address only advance on granted cycles.
        case (state_r)
            ST_IDLE: begin
                pend_s = FALSE_V;
            end
            ST_FETCH: begin
                if (mem.mem_gnt == TRUE_V) begin
                    pend_s = TRUE_V;
                    tag_s  = idx_r;
                    if (idx_r == 2'd3) begin
                        state_s = ST_DRAIN;
                        req_s   = FALSE_V;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        mem_a_s = mem_a_r + ADDR_W'(1);
                    end
                end else begin
                    pend_s = FALSE_V;
                end
            end
            ST_DRAIN: begin
                pend_s = FALSE_V;
            end
            default: begin
                state_s = ST_IDLE;
                pend_s  = FALSE_V;
                req_s   = FALSE_V;
                busy_s  = FALSE_V;
            end
        endcase

        // Byte sample: the RAM answers the previous cycle's granted address.
        if (pend_r == TRUE_V) begin
            asm_s = set_lane(asm_r, tag_r, mem.mem_din);
        end else begin
            asm_s = asm_r;
        end

        // Completion presents the word and refills the buffer.
        if (complete_s) begin
            rdata_s    = set_lane(asm_r, 2'd3, mem.mem_din);
            busy_s     = FALSE_V;
            state_s    = ST_IDLE;
            buf_addr_s = addr_r;
            buf_data_s = rdata_s;
        end else begin
            rdata_s    = rdata_r;
            buf_addr_s = buf_addr_r;
            buf_data_s = buf_data_r;
        end

        // A flush on the completing edge wins: the word may already be stale.
        if (inst_flush == TRUE_V) begin
            buf_valid_s = FALSE_V;
        end else if (complete_s) begin
            buf_valid_s = TRUE_V;
        end else begin
            buf_valid_s = buf_valid_r;
        end

        // New request: hit answers from the buffer, otherwise (re)start at byte 0.
        if (inst_re == TRUE_V) begin
            if (hit_s) begin
                rdata_s = buf_data_r;
            end else begin
                addr_s  = req_addr_s;
                mem_a_s = req_addr_s;
                idx_s   = 2'd0;
                tag_s   = 2'd0;
                pend_s  = FALSE_V;
                asm_s   = ZERO_WORD;
                state_s = ST_FETCH;
                req_s   = TRUE_V;
                busy_s  = TRUE_V;
            end
        end else begin
            addr_s = addr_s;
        end
    end

    // State and datapath registers; rdy=0 holds everything.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            idx_r       <= 2'd0;
            pend_r      <= FALSE_V;
            tag_r       <= 2'd0;
            asm_r       <= ZERO_WORD;
            rdata_r     <= ZERO_WORD;
            busy_r      <= FALSE_V;
            req_r       <= FALSE_V;
            mem_a_r     <= {ADDR_W{1'b0}};
            buf_valid_r <= FALSE_V;
            buf_addr_r  <= {ADDR_W{1'b0}};
            buf_data_r  <= ZERO_WORD;
        end else if (rdy == TRUE_V) begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            idx_r       <= idx_s;
            pend_r      <= pend_s;
            tag_r       <= tag_s;
            asm_r       <= asm_s;
            rdata_r     <= rdata_s;
            busy_r      <= busy_s;
            req_r       <= req_s;
            mem_a_r     <= mem_a_s;
            buf_valid_r <= buf_valid_s;
            buf_addr_r  <= buf_addr_s;
            buf_data_r  <= buf_data_s;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
// Directed bench for inst_fetch_ctrl with a byte RAM model behind the port.
// Expected words are pushed to a queue when a fetch is issued and popped when
// the fetch completes (or is answered from the buffer).
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          inst_re;
    logic [31:0]   inst_raddr;
    logic          inst_flush;
    logic [31:0]   inst_rdata;
    logic          inst_busy;
    logic          gnt;

    logic [7:0]    ram [0:255];
    logic [AW-1:0] a_tr [0:63];
    logic [31:0]   exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            nb;

    inst_fetch_ctrl_if #(.ADDR_W(AW)) mif ();
    assign mif.mem_gnt = gnt;

    inst_fetch_ctrl #(.ADDR_W(AW), .USE_BUF(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .inst_re    (inst_re),
        .inst_raddr (inst_raddr),
        .inst_flush (inst_flush),
        .inst_rdata (inst_rdata),
        .inst_busy  (inst_busy),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    // RAM: registered read, holds its output while rdy is low.
    always @(posedge clk) begin
        if (rdy) mif.mem_din <= ram[mif.mem_a[7:0]];
    end

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [7:0] b0;
        b0 = a[7:0] & 8'hFC;
        return {ram[b0 + 8'd3], ram[b0 + 8'd2], ram[b0 + 8'd1], ram[b0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed output with empty expected queue", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, inst_rdata, e);
        end
    endtask

    task automatic start(input logic [31:0] addr, input logic flush);
        inst_raddr = addr;
        inst_re    = 1'b1;
        inst_flush = flush;
        tick();
        inst_re    = 1'b0;
        inst_flush = 1'b0;
    endtask

    // Steps busy cycles (1-based count n), recording mem_a per cycle and
    // applying optional grant gap, rdy freeze and redirect.
    task automatic run(input int g0, input int glen, input int r0, input int rlen,
                       input int redir_at, input logic [31:0] redir_addr, output int n);
        n = 0;
        while (inst_busy === 1'b1 && n < 60) begin
            n++;
            a_tr[n] = mif.mem_a;
            gnt = (n >= g0 && n < g0 + glen) ? 1'b0 : 1'b1;
            rdy = (n >= r0 && n < r0 + rlen) ? 1'b0 : 1'b1;
            if (n == redir_at) begin
                inst_re    = 1'b1;
                inst_raddr = redir_addr;
            end else begin
                inst_re    = 1'b0;
            end
            tick();
        end
        gnt     = 1'b1;
        rdy     = 1'b1;
        inst_re = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; inst_re = 1'b0; inst_flush = 1'b0;
        inst_raddr = 32'd0; gnt = 1'b1;
        for (int i = 0; i < 256; i++) ram[i] = 8'((i * 37) + 11);
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;

        tick(); tick();
        check("rst_busy",  {31'd0, inst_busy}, 32'd0);
        check("rst_rdata", inst_rdata, 32'd0);
        check("rst_req",   {31'd0, mif.mem_req}, 32'd0);
        check("rst_mem_a", 32'(mif.mem_a), 32'd0);
        rst = 1'b0;
        tick();

        // Plain fetch of word 0.
        exp_q.push_back(32'h0000_0513);
        start(32'h0, 1'b0);
        run(0, 0, 0, 0, 0, 32'h0, nb);
        check("t1_busy_len", 32'(nb), 32'd5);
        for (int k = 0; k < 4; k++) check("t1_mem_a", 32'(a_tr[k + 1]), 32'(k));
        sb_check("t1_word");

        // Refetch same word: buffer hit.
        exp_q.push_back(32'h0000_0513);
        start(32'h0, 1'b0);
        check("t2_busy", {31'd0, inst_busy}, 32'd0);
        check("t2_req",  {31'd0, mif.mem_req}, 32'd0);
        sb_check("t2_word");
        tick();
        check("t2_busy_after", {31'd0, inst_busy}, 32'd0);

        // Grant gap of 3 cycles while byte 1 is requested.
        exp_q.push_back(model_word(32'h4));
        start(32'h4, 1'b0);
        run(2, 3, 0, 0, 0, 32'h0, nb);
        check("t3_busy_len", 32'(nb), 32'd8);
        for (int k = 2; k < 6; k++) check("t3_mem_a_hold", 32'(a_tr[k]), 32'h5);
        check("t3_mem_a_next", 32'(a_tr[6]), 32'h6);
        sb_check("t3_word");

        // Redirect from 0x8 to 0x40 on the third busy cycle.
        exp_q.push_back(model_word(32'h40));
        start(32'h8, 1'b0);
        run(0, 0, 0, 0, 3, 32'h40, nb);
        check("t4_busy_len", 32'(nb), 32'd8);
        check("t4_mem_a_old", 32'(a_tr[3]), 32'hA);
        check("t4_mem_a_new", 32'(a_tr[4]), 32'h40);
        check("t4_mem_a_new1", 32'(a_tr[5]), 32'h41);
        sb_check("t4_word");
        exp_q.push_back(model_word(32'h40));
        start(32'h40, 1'b0);
        check("t4_buf_hit_busy", {31'd0, inst_busy}, 32'd0);
        check("t4_buf_hit_req",  {31'd0, mif.mem_req}, 32'd0);
        sb_check("t4_buf_word");
        exp_q.push_back(model_word(32'h8));
        start(32'h8, 1'b0);
        check("t4_old_miss", {31'd0, inst_busy}, 32'd1);
        run(0, 0, 0, 0, 0, 32'h0, nb);
        check("t4_old_len", 32'(nb), 32'd5);
        sb_check("t4_old_word");

        // rdy low for 4 cycles mid-fetch.
        exp_q.push_back(model_word(32'hC));
        start(32'hC, 1'b0);
        run(0, 0, 2, 4, 0, 32'h0, nb);
        check("t5_busy_len", 32'(nb), 32'd9);
        for (int k = 2; k < 6; k++) check("t5_mem_a_frozen", 32'(a_tr[k]), 32'hD);
        sb_check("t5_word");

        // Flush together with refetch of the buffered word: full RAM fetch.
        exp_q.push_back(model_word(32'hC));
        start(32'hC, 1'b1);
        check("t6_flush_busy", {31'd0, inst_busy}, 32'd1);
        check("t6_flush_req",  {31'd0, mif.mem_req}, 32'd1);
        run(0, 0, 0, 0, 0, 32'h0, nb);
        check("t6_flush_len", 32'(nb), 32'd5);
        sb_check("t6_flush_word");

        // Reset on cycle 2 of a fetch aborts it.
        start(32'h10, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("t6_rst_busy",  {31'd0, inst_busy}, 32'd0);
        check("t6_rst_req",   {31'd0, mif.mem_req}, 32'd0);
        check("t6_rst_rdata", inst_rdata, 32'd0);
        check("t6_rst_mem_a", 32'(mif.mem_a), 32'd0);
        rst = 1'b0;
        tick();

        // Buffer was invalidated by reset.
        exp_q.push_back(model_word(32'hC));
        start(32'hC, 1'b0);
        check("t6_post_rst_miss", {31'd0, inst_busy}, 32'd1);
        run(0, 0, 0, 0, 0, 32'h0, nb);
        check("t6_post_rst_len", 32'(nb), 32'd5);
        sb_check("t6_post_rst_word");

        // Upper address bits and byte offset ignored.
        exp_q.push_back(model_word(32'h1FFFC));
        start(32'hFFFF_FFFE, 1'b0);
        run(0, 0, 0, 0, 0, 32'h0, nb);
        check("t7_mem_a_lo", 32'(a_tr[1]), 32'h1FFFC);
        check("t7_mem_a_hi", 32'(a_tr[4]), 32'h1FFFF);
        sb_check("t7_word");

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Memory-side instruction fetch controller sitting directly upstream of the IF stage, which drives its inst_re/inst_raddr request and consumes inst_rdata/inst_busy.
- Turns each 32-bit fetch into four sequential byte reads on the 8-bit unified RAM port, via the memory arbiter (mem_req/mem_gnt).
- Assembles the bytes little-endian.
- Keeps a one-entry last-word buffer for 1-cycle refetch of the same address.

Parameters:
ADDR_W, 17, width of the RAM byte address.
USE_BUF, 1, 1 enables the last-word buffer; 0 forces every request to go to RAM.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes all state
inst_re  in  1  fetch request strobe from IF, one cycle wide
inst_raddr  in  32  fetch byte address; bits [1:0] ignored (word aligned)
inst_flush  in  1  invalidate last-word buffer (fence.i, store into code region)
inst_rdata  out  32  assembled instruction, valid while inst_busy=0 after a fetch
inst_busy  out  1  high while a fetch is outstanding
mem_req  out  1  request for the RAM port to the arbiter
mem_gnt  in  1  arbiter grant; mem_a is driven to RAM only in granted cycles
mem_a  out  ADDR_W  RAM byte address
mem_din  in  8  RAM read data; returns byte for mem_a one cycle later

Behaviour:
- Clock and reset: clk clocks the block; reset rst is synchronous, active-high.
- Reset values: inst_busy=0, inst_rdata=0, mem_req=0, mem_a=0, state=IDLE, buffer invalid, counters=0.
  - Reset mid-fetch aborts the fetch; no data is presented.
- rdy=0: every register holds, including the pending sampled-byte flag. The RAM holds mem_din during rdy=0.
- Accept: at an edge with rdy=1 and inst_re=1, latch word address A = {inst_raddr[ADDR_W-1:2],2'b00}.
- Buffer hit: USE_BUF=1, buffer valid, buf_addr==A, and inst_flush=0.
  - Next edge: inst_busy stays 0 and inst_rdata<=buf_data.
  - Hit latency is 1 cycle; no RAM access.
- Miss: inst_busy<=1, mem_req<=1, state<=FETCH, issue index i<=0.
- States:
  - IDLE: wait for inst_re.
  - FETCH: issue bytes 0..3.
  - DRAIN: last byte in flight.
- Issue (FETCH):
  - mem_a=A+i.
  - At an edge where mem_gnt=1, i increments and pend<=1 with tag i.
  - When mem_gnt=0, i and mem_a hold and pend<=0.
  - After i=3 is granted: state<=DRAIN, mem_req<=0.
- Sample: at any edge with pend=1, mem_din is written to byte lane tag of the assembly register.
- Complete: when lane 3 is sampled:
  - inst_rdata<=assembly with lane 3 = mem_din;
  - inst_busy<=0, state<=IDLE;
  - buf_addr<=A, buf_data<=word, buffer valid<=1.
- Latency: with mem_gnt and rdy always 1, inst_busy is high for exactly 5 cycles and inst_rdata is valid on edge 5 after accept.
- Redirect: inst_re=1 while busy aborts the current fetch on that edge.
  - The assembly register is discarded and pend is cleared.
  - The new address A' restarts at i=0; inst_busy stays 1. The old word is never presented or buffered.
- inst_flush=1: buffer valid<=0 at that edge.
  - Flush with a simultaneous inst_re to the buffered address is a miss.
  - Flush during FETCH does not block the completing fetch from refilling the buffer.
- Address arithmetic: A+i is computed in ADDR_W bits and wraps modulo 2^ADDR_W. Upper inst_raddr bits above ADDR_W are ignored.
- inst_rdata holds its last value while busy and while IDLE.

Decomposition:
- Shared defines.v supplies: RstEnable, True_v, False_v, ZeroWord, and InstAddrBus/RamAddrBus widths.
- State encodings (IDLE/FETCH/DRAIN) are local parameters.
- No sub-module: the buffer and byte assembler are small enough to stay inline.

Test Plan:
- Preload RAM 0x0000..0x0003 = 13,05,00,00. inst_re with addr 0x0 -> mem_a 0,1,2,3 on consecutive cycles; inst_busy high 5 cycles; inst_rdata=0x00000513.
- Refetch 0x0 with no flush -> inst_busy never rises; inst_rdata=0x00000513 one cycle later; mem_req stays 0.
- Fetch 0x4 with mem_gnt low for 3 cycles after the second byte -> mem_a holds 0x5 during the gap; busy lasts 8 cycles; word correct.
- Fetch 0x8, then inst_re to 0x40 on the third busy cycle -> mem_a restarts at 0x40; result = word at 0x40; buffer holds 0x40, not 0x8.
- rdy=0 for 4 cycles mid-fetch -> mem_a and state frozen; fetch completes 4 cycles late with the correct word.
- inst_flush together with refetch of the buffered address, then rst asserted on cycle 2 of a fetch -> flush: full 5-cycle RAM fetch; rst: inst_busy=0, mem_req=0, inst_rdata=0 next cycle.
